// File: rtl/valu_issue_ctrl_if.sv
// Issue-controller bus: instruction handshake, register-file read port, ALU operand
// drive and byte-masked write-back, grouped so the controller takes a single port.
interface valu_issue_ctrl_if;
    // instr_valid/instr_ready: an instruction transfers on a rising edge where both are 1;
    // the source holds instr_valid and instr stable until that edge.
    logic        instr_valid;
    logic        instr_ready;
    logic [0:31] instr;
    logic [0:4]  rf_addr_a;
    logic [0:4]  rf_addr_b;
    logic [0:63] rf_data_a;
    logic [0:63] rf_data_b;
    logic [0:63] alu_rA;
    logic [0:63] alu_rB;
    logic [0:5]  alu_R_ins;
    logic [0:5]  alu_Op_code;
    logic [0:1]  alu_WW;
    logic [0:63] alu_result;
    logic        wb_valid;
    logic [0:4]  wb_addr;
    logic [0:63] wb_data;
    logic [0:7]  wb_mask;
    logic        illegal;

    modport slave (
        input  instr_valid, instr, rf_data_a, rf_data_b, alu_result,
        output instr_ready, rf_addr_a, rf_addr_b, alu_rA, alu_rB, alu_R_ins,
               alu_Op_code, alu_WW, wb_valid, wb_addr, wb_data, wb_mask, illegal
    );

    modport master (
        output instr_valid, instr, rf_data_a, rf_data_b, alu_result,
        input  instr_ready, rf_addr_a, rf_addr_b, alu_rA, alu_rB, alu_R_ins,
               alu_Op_code, alu_WW, wb_valid, wb_addr, wb_data, wb_mask, illegal
    );
endinterface

// File: rtl/valu_issue_ctrl.sv
// Vector-ALU issue controller: decodes one R-type instruction, reads rA/rB, holds the
// operands on the ALU for EXEC_CYCLES cycles and issues a byte-masked write-back to rD.
module valu_issue_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    valu_issue_ctrl_if.slave bus,
    output logic [1:0]       dbg_state_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [0:5] OP_VALU   = 6'b101010;
    localparam logic [0:5] FUNC_MIN  = 6'b000001;
    localparam logic [0:5] FUNC_MAX  = 6'b010010;
    localparam logic [0:2] PPP_MAX   = 3'b100;
    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [0:4]  rd_q, rd_d;
    logic [0:4]  addr_a_q, addr_a_d;
    logic [0:4]  addr_b_q, addr_b_d;
    logic [0:2]  ppp_q, ppp_d;
    logic [0:5]  func_q, func_d;
    logic [0:5]  op_q, op_d;
    logic [0:1]  ww_q, ww_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [0:63] alu_ra_q, alu_ra_d;
    logic [0:63] alu_rb_q, alu_rb_d;
    logic [0:5]  alu_rins_q, alu_rins_d;
    logic [0:5]  alu_op_q, alu_op_d;
    logic [0:1]  alu_ww_q, alu_ww_d;
    logic [0:63] wb_data_q, wb_data_d;
    logic [0:4]  wb_addr_q, wb_addr_d;
    logic [0:7]  wb_mask_q, wb_mask_d;
    logic        illegal_q, illegal_d;

    logic [0:5] dec_op, dec_func;
    logic [0:4] dec_rd, dec_ra, dec_rb;
    logic [0:2] dec_ppp;
    logic [0:1] dec_ww;
    logic       dec_legal;
    logic       accept;

    assign dec_op   = bus.instr[0:5];
    assign dec_rd   = bus.instr[6:10];
    assign dec_ra   = bus.instr[11:15];
    assign dec_rb   = bus.instr[16:20];
    assign dec_ppp  = bus.instr[21:23];
    assign dec_ww   = bus.instr[24:25];
    assign dec_func = bus.instr[26:31];

    assign dec_legal = (dec_op == OP_VALU) && (dec_func >= FUNC_MIN) &&
                       (dec_func <= FUNC_MAX) && (dec_ppp <= PPP_MAX);
    assign accept    = (state_q == S_IDLE) && bus.instr_valid;

    function automatic logic [0:7] ppp_mask(input logic [0:2] ppp);
        case (ppp)
            3'b000:  ppp_mask = 8'hFF;
            3'b001:  ppp_mask = 8'hF0;
            3'b010:  ppp_mask = 8'h0F;
            3'b011:  ppp_mask = 8'hAA;
            3'b100:  ppp_mask = 8'h55;
            default: ppp_mask = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        ppp_d      = ppp_q;
        func_d     = func_q;
        op_d       = op_q;
        ww_d       = ww_q;
        cnt_d      = cnt_q;
        alu_ra_d   = alu_ra_q;
        alu_rb_d   = alu_rb_q;
        alu_rins_d = alu_rins_q;
        alu_op_d   = alu_op_q;
        alu_ww_d   = alu_ww_q;
        wb_data_d  = wb_data_q;
        wb_addr_d  = wb_addr_q;
        wb_mask_d  = wb_mask_q;
        illegal_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (dec_legal) begin
                        rd_d     = dec_rd;
                        addr_a_d = dec_ra;
                        addr_b_d = dec_rb;
                        ppp_d    = dec_ppp;
                        func_d   = dec_func;
                        op_d     = dec_op;
                        ww_d     = dec_ww;
                        state_d  = S_READ;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                alu_ra_d   = bus.rf_data_a;
                alu_rb_d   = bus.rf_data_b;
                alu_rins_d = func_q;
                alu_op_d   = op_q;
                alu_ww_d   = ww_q;
                cnt_d      = 4'd0;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                if (cnt_q == EXEC_LAST) begin
                    wb_data_d = bus.alu_result;
                    wb_addr_d = rd_q;
                    wb_mask_d = ppp_mask(ppp_q);
                    cnt_d     = 4'd0;
                    state_d   = S_WB;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rd_q       <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            ppp_q      <= '0;
            func_q     <= '0;
            op_q       <= '0;
            ww_q       <= '0;
            cnt_q      <= '0;
            alu_ra_q   <= '0;
            alu_rb_q   <= '0;
            alu_rins_q <= '0;
            alu_op_q   <= '0;
            alu_ww_q   <= '0;
            wb_data_q  <= '0;
            wb_addr_q  <= '0;
            wb_mask_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            ppp_q      <= ppp_d;
            func_q     <= func_d;
            op_q       <= op_d;
            ww_q       <= ww_d;
            cnt_q      <= cnt_d;
            alu_ra_q   <= alu_ra_d;
            alu_rb_q   <= alu_rb_d;
            alu_rins_q <= alu_rins_d;
            alu_op_q   <= alu_op_d;
            alu_ww_q   <= alu_ww_d;
            wb_data_q  <= wb_data_d;
            wb_addr_q  <= wb_addr_d;
            wb_mask_q  <= wb_mask_d;
            illegal_q  <= illegal_d;
        end
    end

    // The synchronous register file samples the address on the accept edge itself, so the
    // decoded rA/rB are presented combinationally while a legal instruction is offered.
    assign bus.rf_addr_a   = (accept && dec_legal) ? dec_ra : addr_a_q;
    assign bus.rf_addr_b   = (accept && dec_legal) ? dec_rb : addr_b_q;
    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.alu_rA      = alu_ra_q;
    assign bus.alu_rB      = alu_rb_q;
    assign bus.alu_R_ins   = alu_rins_q;
    assign bus.alu_Op_code = alu_op_q;
    assign bus.alu_WW      = alu_ww_q;
    assign bus.wb_valid    = (state_q == S_WB);
    assign bus.wb_addr     = wb_addr_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_mask     = wb_mask_q;
    assign bus.illegal     = illegal_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_valu_issue_ctrl.sv
// Bench for valu_issue_ctrl: two instances (EXEC_CYCLES 1 and 3) share one instruction
// stream; a transaction-level model predicts write-backs, illegal pulses and accept spacing.
module tb_valu_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    localparam logic [5:0] OP = 6'b101010;

    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [63:0] data;
        logic [7:0]  mask;
        logic [63:0] a;
        logic [63:0] b;
        logic [5:0]  func;
        logic [5:0]  op;
        logic [1:0]  ww;
        logic [4:0]  ra;
    } exp_t;

    logic        src_valid [2];
    logic [31:0] src_instr [2];
    logic        ready_s   [2];
    logic        wbv_s     [2];
    logic        ill_s     [2];
    logic [4:0]  ra_s      [2];
    logic [4:0]  rb_s      [2];
    logic [4:0]  wba_s     [2];
    logic [63:0] wbd_s     [2];
    logic [7:0]  wbm_s     [2];
    logic [63:0] alua_s    [2];
    logic [63:0] alub_s    [2];
    logic [5:0]  rins_s    [2];
    logic [5:0]  op_s      [2];
    logic [1:0]  ww_s      [2];
    logic [1:0]  dbg_s     [2];
    logic [63:0] rd_a      [2];
    logic [63:0] rd_b      [2];
    logic [63:0] rf        [2][32];

    exp_t        exp_q     [2][$];
    int          ill_q     [2][$];
    logic [31:0] pend_q    [2][$];
    exp_t        last_e    [2];
    logic        acc       [2];
    logic        b2b       [2];
    logic        last_legal[2];
    int          last_acc  [2];
    int          exec_n    [2];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    // Reference ALU: AND, MOV, lane-wise ADD of width 8<<WW; any other func mixes operands.
    function automatic logic [63:0] alu_fn(input logic [5:0] op, input logic [5:0] func,
                                           input logic [1:0] ww, input logic [63:0] a,
                                           input logic [63:0] b);
        logic [63:0] r, s, lm;
        int w;
        r = '0;
        case (func)
            6'd1: r = a & b;
            6'd5: r = a;
            6'd6: begin
                w  = 8 << ww;
                lm = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
                for (int i = 0; i < 64; i += w) begin
                    s = ((a >> i) + (b >> i)) & lm;
                    r = r | (s << i);
                end
            end
            default: r = (a ^ b) + {58'd0, op};
        endcase
        return r;
    endfunction

    // Byte i of the write-back is wb_mask bit i, counted from the MSB side.
    function automatic logic [7:0] mask_of(input logic [2:0] p);
        logic [7:0] m;
        logic en;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            en = (p == 3'd0) || (p == 3'd1 && i < 4) || (p == 3'd2 && i >= 4) ||
                 (p == 3'd3 && i % 2 == 0) || (p == 3'd4 && i % 2 == 1);
            m[7-i] = en;
        end
        return m;
    endfunction

    function automatic logic legal_of(input logic [31:0] ins);
        return (ins[31:26] == OP) && (ins[5:0] >= 6'd1) && (ins[5:0] <= 6'd18) &&
               (ins[10:8] <= 3'd4);
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb,
                                       input logic [2:0] ppp, input logic [1:0] ww,
                                       input logic [5:0] func);
        return {op, rd, ra, rb, ppp, ww, func};
    endfunction

    valu_issue_ctrl_if bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        valu_issue_ctrl #(.EXEC_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .bus         (bus[g]),
            .dbg_state_o (dbg_s[g])
        );
        assign bus[g].instr_valid = src_valid[g];
        assign bus[g].instr       = src_instr[g];
        assign bus[g].rf_data_a   = rd_a[g];
        assign bus[g].rf_data_b   = rd_b[g];
        assign bus[g].alu_result  = alu_fn(op_s[g], rins_s[g], ww_s[g], alua_s[g], alub_s[g]);
        assign ready_s[g] = bus[g].instr_ready;
        assign wbv_s[g]   = bus[g].wb_valid;
        assign ill_s[g]   = bus[g].illegal;
        assign ra_s[g]    = bus[g].rf_addr_a;
        assign rb_s[g]    = bus[g].rf_addr_b;
        assign wba_s[g]   = bus[g].wb_addr;
        assign wbd_s[g]   = bus[g].wb_data;
        assign wbm_s[g]   = bus[g].wb_mask;
        assign alua_s[g]  = bus[g].alu_rA;
        assign alub_s[g]  = bus[g].alu_rB;
        assign rins_s[g]  = bus[g].alu_R_ins;
        assign op_s[g]    = bus[g].alu_Op_code;
        assign ww_s[g]    = bus[g].alu_WW;
    end

    // Synchronous-read register file model.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            rd_a[d] <= rf[d][ra_s[d]];
            rd_b[d] <= rf[d][rb_s[d]];
        end
    end

    task automatic chk(input string tag, input int d, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, d, obs, exp_v);
        end
    endtask

    function automatic exp_t zero_e();
        exp_t e;
        e.due = 0; e.addr = '0; e.data = '0; e.mask = '0; e.a = '0; e.b = '0;
        e.func = '0; e.op = '0; e.ww = '0; e.ra = '0;
        return e;
    endfunction

    task automatic push(input logic [31:0] ins);
        pend_q[0].push_back(ins);
        pend_q[1].push_back(ins);
    endtask

    task automatic set_rf(input int r, input logic [63:0] v);
        rf[0][r] = v;
        rf[1][r] = v;
    endtask

    task automatic step();
        exp_t e;
        logic exp_ill;
        logic [31:0] ins;
        for (int d = 0; d < 2; d++) begin
            if (wbv_s[d]) begin
                for (int i = 0; i < 8; i++)
                    if (wbm_s[d][7-i]) rf[d][wba_s[d]][63-8*i -: 8] = wbd_s[d][63-8*i -: 8];
            end
            acc[d] = src_valid[d] && ready_s[d];
            if (acc[d]) begin
                ins = src_instr[d];
                if (legal_of(ins)) begin
                    e.op = ins[31:26]; e.addr = ins[25:21]; e.ra = ins[20:16];
                    e.ww = ins[7:6];   e.func = ins[5:0];
                    e.a = rf[d][ins[20:16]];
                    e.b = rf[d][ins[15:11]];
                    e.data = alu_fn(e.op, e.func, e.ww, e.a, e.b);
                    e.mask = mask_of(ins[10:8]);
                    e.due = cyc + 2 + exec_n[d];
                    exp_q[d].push_back(e);
                end else begin
                    ill_q[d].push_back(cyc + 1);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (acc[d]) begin
                if (b2b[d]) chk("accept_spacing", d, cyc - last_acc[d],
                                last_legal[d] ? 3 + exec_n[d] : 1);
                last_acc[d] = cyc;
                last_legal[d] = legal_of(src_instr[d]);
                void'(pend_q[d].pop_front());
                src_valid[d] = 1'b0;
            end
            if (wbv_s[d]) begin
                if (exp_q[d].size() == 0) begin
                    chk("wb_unexpected", d, wbv_s[d], 0);
                end else begin
                    e = exp_q[d].pop_front();
                    chk("wb_cycle", d, cyc, e.due);
                    chk("wb_addr", d, wba_s[d], e.addr);
                    chk("wb_data", d, wbd_s[d], e.data);
                    chk("wb_mask", d, wbm_s[d], e.mask);
                    chk("alu_rA", d, alua_s[d], e.a);
                    chk("alu_rB", d, alub_s[d], e.b);
                    chk("alu_R_ins", d, rins_s[d], e.func);
                    chk("alu_Op_code", d, op_s[d], e.op);
                    chk("alu_WW", d, ww_s[d], e.ww);
                    last_e[d] = e;
                end
            end else if (exp_q[d].size() > 0 && exp_q[d][0].due <= cyc) begin
                chk("wb_missing", d, wbv_s[d], 1);
                void'(exp_q[d].pop_front());
            end
            exp_ill = (ill_q[d].size() > 0) && (ill_q[d][0] == cyc);
            if (exp_ill) void'(ill_q[d].pop_front());
            chk("illegal", d, ill_s[d], exp_ill);
            if (exp_ill) begin
                chk("ill_ready", d, ready_s[d], 1);
                chk("ill_alu_rA", d, alua_s[d], last_e[d].a);
                chk("ill_alu_rB", d, alub_s[d], last_e[d].b);
                chk("ill_alu_R_ins", d, rins_s[d], last_e[d].func);
                chk("ill_alu_Op_code", d, op_s[d], last_e[d].op);
            end
            if (!src_valid[d] && pend_q[d].size() > 0) begin
                src_instr[d] = pend_q[d][0];
                src_valid[d] = 1'b1;
                b2b[d] = acc[d];
            end
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            pend_q[d].delete();
            exp_q[d].delete();
            ill_q[d].delete();
            src_valid[d] = 1'b0;
            b2b[d] = 1'b0;
            last_e[d] = zero_e();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (pend_q[0].size() + pend_q[1].size() + exp_q[0].size() + exp_q[1].size() +
               ill_q[0].size() + ill_q[1].size() != 0 || src_valid[0] || src_valid[1]) begin
            if (n >= 500) begin
                chk("drain_timeout", 0, n, 0);
                clear_model();
                break;
            end
            step();
            n++;
        end
        step();
        step();
    endtask

    task automatic chk_reset_outputs();
        for (int d = 0; d < 2; d++) begin
            chk("rst_instr_ready", d, ready_s[d], 1);
            chk("rst_wb_valid", d, wbv_s[d], 0);
            chk("rst_illegal", d, ill_s[d], 0);
            chk("rst_rf_addr_a", d, ra_s[d], 0);
            chk("rst_rf_addr_b", d, rb_s[d], 0);
            chk("rst_wb_addr", d, wba_s[d], 0);
            chk("rst_wb_data", d, wbd_s[d], 0);
            chk("rst_wb_mask", d, wbm_s[d], 0);
            chk("rst_alu_rA", d, alua_s[d], 0);
            chk("rst_alu_rB", d, alub_s[d], 0);
            chk("rst_alu_R_ins", d, rins_s[d], 0);
            chk("rst_alu_Op_code", d, op_s[d], 0);
            chk("rst_alu_WW", d, ww_s[d], 0);
        end
    endtask

    initial begin
        int n;
        exec_n[0] = 1;
        exec_n[1] = 3;
        for (int d = 0; d < 2; d++) begin
            src_valid[d] = 1'b0;
            src_instr[d] = '0;
            last_acc[d] = 0;
            last_legal[d] = 1'b0;
        end
        for (int r = 0; r < 32; r++) set_rf(r, {$urandom, $urandom});
        clear_model();

        // Clock/reset.
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        step();
        step();
        rst_n = 1'b1;
        step();

        // VAND.
        set_rf(1, 64'd15);
        set_rf(2, 64'd14);
        push(mk(OP, 5'd3, 5'd1, 5'd2, 3'b000, 2'b10, 6'b000001));
        drain();
        for (int d = 0; d < 2; d++) begin
            chk("t1_wb_data", d, wbd_s[d], 64'd14);
            chk("t1_wb_addr", d, wba_s[d], 64'd3);
            chk("t1_wb_mask", d, wbm_s[d], 64'hFF);
        end

        // VADD with 8-bit lanes.
        set_rf(1, 64'hFFFFFFFF_FFFFFFFF);
        set_rf(2, 64'h00000000_11111111);
        push(mk(OP, 5'd4, 5'd1, 5'd2, 3'b000, 2'b00, 6'b000110));
        drain();
        for (int d = 0; d < 2; d++) chk("t2_wb_data", d, wbd_s[d], 64'hFFFFFFFF_10101010);

        // PPP sweep on VMOV, back to back, ending with the illegal PPP=101.
        for (int p = 0; p < 6; p++)
            push(mk(OP, 5'(10 + p), 5'd1, 5'd2, 3'(p), 2'b11, 6'b000101));
        drain();
        for (int d = 0; d < 2; d++) chk("t3_last_mask", d, wbm_s[d], 64'h55);

        // Illegal encodings only: nothing but illegal pulses, addresses unchanged.
        push(mk(6'b000000, 5'd5, 5'd6, 5'd7, 3'b000, 2'b00, 6'b000001));
        push(mk(OP, 5'd5, 5'd6, 5'd7, 3'b000, 2'b00, 6'b010011));
        push(mk(OP, 5'd5, 5'd6, 5'd7, 3'b000, 2'b00, 6'b000000));
        push(mk(OP, 5'd5, 5'd6, 5'd7, 3'b111, 2'b00, 6'b000101));
        drain();
        for (int d = 0; d < 2; d++) chk("t4_rf_addr_a", d, ra_s[d], last_e[d].ra);

        // Back to back, including the highest legal func; rD==rA reads the old value.
        set_rf(7, 64'd100);
        set_rf(8, 64'd5);
        push(mk(OP, 5'd7, 5'd7, 5'd8, 3'b000, 2'b11, 6'b000110));
        push(mk(OP, 5'd9, 5'd7, 5'd8, 3'b000, 2'b11, 6'b000101));
        push(mk(OP, 5'd11, 5'd3, 5'd4, 3'b010, 2'b01, 6'b010010));
        drain();
        for (int d = 0; d < 2; d++) chk("t5_raw_old", d, rf[d][9], 64'd105);

        // Random mix of legal and illegal instructions.
        for (int k = 0; k < 40; k++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : OP;
            push(mk(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 3'($urandom_range(0, 5)),
                    2'($urandom_range(0, 3)), 6'($urandom_range(0, 20))));
        end
        drain();

        // Reset while both instances are in EXEC: the instruction is dropped.
        push(mk(OP, 5'd12, 5'd1, 5'd2, 3'b000, 2'b00, 6'b000001));
        n = 0;
        while (exp_q[0].size() == 0 && n < 20) begin
            step();
            n++;
        end
        step();
        for (int d = 0; d < 2; d++) chk("pre_rst_busy", d, ready_s[d], 0);
        rst_n = 1'b0;
        #1;
        clear_model();
        chk_reset_outputs();
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) step();
        push(mk(OP, 5'd13, 5'd7, 5'd8, 3'b001, 2'b11, 6'b000110));
        drain();
        for (int d = 0; d < 2; d++) chk("post_rst_wb_addr", d, wba_s[d], 64'd13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
